key_stim_gen: RTL and testbench

- Synthesizable transmitter for the active-low push-button line (`key_in`) consumed by `led_top`.
- On command, drives a key press/release waveform with programmable contact bounce and hold time.
- Used for on-board loopback self-test of the key debounce/LED path and as a reusable stimulus source in system sims.
- Sits between a test controller (`start`/`hold`/`bounce` settings) and the `key_in` pin of `led_top`.

---
 rtl/key_stim_gen.sv | 179 +++++++++++++++++
 tb/tb_key_stim_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_stim_gen.sv
// key_stim_gen - emulated active-low push-button source.
//
// On an accepted start, drives key_out through a press/release waveform
// with optional contact bounce on each edge and a programmable hold time.
// Intended for loopback self-test of a key debounce path.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start      request one press sequence (only honoured while idle)
//   hold_len   cycles the key stays low (0 is treated as 1), latched at start
//   bounce_n   glitch pairs per edge (0 = clean edges), latched at start
//   key_out    emulated key line, idle high, pressed low
//   busy       high in every state except IDLE
//   done       one-cycle pulse in the final (released) cycle of a sequence
//   press_cnt  number of completed sequences, wraps
module key_stim_gen #(
  parameter int BW  = 2,   // cycles per bounce half-phase, >= 1
  parameter int CW  = 16,  // hold-length width
  parameter int PCW = 8    // completed-press counter width
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [CW-1:0]  hold_len,
  input  logic [3:0]     bounce_n,
  output logic           key_out,
  output logic           busy,
  output logic           done,
  output logic [PCW-1:0] press_cnt
);

  typedef enum logic [2:0] {IDLE, PRESS_B, HOLD, REL_B, DONE} state_t;

  localparam int PHW = (BW > 1) ? $clog2(BW) : 1;
  localparam logic [PHW-1:0] PH_LAST = PHW'(BW - 1);

  state_t         state_q, state_d;
  logic [PHW-1:0] ph_q, ph_d;          // cycle within current bounce half-phase
  logic [4:0]     half_q, half_d;      // bounce half-phases still to come
  logic [CW-1:0]  hcnt_q, hcnt_d;      // hold cycles remaining minus one
  logic [CW-1:0]  hold_lat_q, hold_lat_d;
  logic [3:0]     bn_q, bn_d;
  logic           key_q, key_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [PCW-1:0] press_q, press_d;

  // Hold length is stored minus one so that a zero request collapses to one cycle.
  logic [CW-1:0] hold_m1;
  assign hold_m1 = (hold_len == '0) ? '0 : hold_len - CW'(1);

  // key_d is always the line level for the cycle that follows the edge,
  // so the output stays a plain register.
  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    half_d     = half_q;
    hcnt_d     = hcnt_q;
    hold_lat_d = hold_lat_q;
    bn_d       = bn_q;
    key_d      = key_q;
    done_d     = 1'b0;
    press_d    = press_q;

    case (state_q)
      IDLE: begin
        key_d = 1'b1;
        if (start) begin
          bn_d       = bounce_n;
          hold_lat_d = hold_m1;
          key_d      = 1'b0;
          if (bounce_n != 4'd0) begin
            state_d = PRESS_B;
            ph_d    = '0;
            half_d  = {bounce_n, 1'b0} - 5'd1;
          end else begin
            state_d = HOLD;
            hcnt_d  = hold_m1;
          end
        end
      end

      PRESS_B: begin
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          if (half_q == 5'd0) begin
            state_d = HOLD;
            hcnt_d  = hold_lat_q;
            key_d   = 1'b0;
          end else begin
            half_d = half_q - 5'd1;
            key_d  = ~key_q;
          end
        end else begin
          ph_d = ph_q + PHW'(1);
        end
      end

      HOLD: begin
        if (hcnt_q == '0) begin
          key_d = 1'b1;
          if (bn_q != 4'd0) begin
            state_d = REL_B;
            ph_d    = '0;
            half_d  = {bn_q, 1'b0} - 5'd1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            press_d = press_q + PCW'(1);
          end
        end else begin
          hcnt_d = hcnt_q - CW'(1);
        end
      end

      REL_B: begin
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          if (half_q == 5'd0) begin
            state_d = DONE;
            key_d   = 1'b1;
            done_d  = 1'b1;
            press_d = press_q + PCW'(1);
          end else begin
            half_d = half_q - 5'd1;
            key_d  = ~key_q;
          end
        end else begin
          ph_d = ph_q + PHW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
        key_d   = 1'b1;
      end

      default: begin
        state_d = IDLE;
        key_d   = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ph_q       <= '0;
      half_q     <= '0;
      hcnt_q     <= '0;
      hold_lat_q <= '0;
      bn_q       <= '0;
      key_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      press_q    <= '0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      half_q     <= half_d;
      hcnt_q     <= hcnt_d;
      hold_lat_q <= hold_lat_d;
      bn_q       <= bn_d;
      key_q      <= key_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      press_q    <= press_d;
    end
  end

  assign key_out   = key_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign press_cnt = press_q;

endmodule

// File: tb/tb_key_stim_gen.sv
// tb_key_stim_gen - self-checking bench for key_stim_gen.
// A queue-based model expands each accepted request into its expected
// per-cycle {done,key} sequence; a compare process checks every cycle,
// and directed scenarios add hand-computed literal expectations.
module tb_key_stim_gen;
  localparam int BW  = 2;
  localparam int CW  = 16;
  localparam int PCW = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [CW-1:0]  hold_len = '0;
  logic [3:0]     bounce_n = '0;
  logic           key_out;
  logic           busy;
  logic           done;
  logic [PCW-1:0] press_cnt;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  bit chk_en   = 1'b0;

  key_stim_gen #(.BW(BW), .CW(CW), .PCW(PCW)) dut (
    .clk(clk), .rst(rst), .start(start), .hold_len(hold_len),
    .bounce_n(bounce_n), .key_out(key_out), .busy(busy), .done(done),
    .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // ---------------- model ----------------
  logic [1:0]     mq[$];      // {done,key} per future busy cycle
  bit             m_busy = 1'b0;
  logic [PCW-1:0] m_cnt  = '0;
  logic           e_key, e_busy, e_done;

  task automatic build_seq(input logic [3:0] bn, input logic [CW-1:0] hl);
    int h;
    h = (hl == 0) ? 1 : int'(hl);
    for (int p = 0; p < bn; p++) begin
      for (int i = 0; i < BW; i++) mq.push_back(2'b00);
      for (int i = 0; i < BW; i++) mq.push_back(2'b01);
    end
    for (int i = 0; i < h; i++) mq.push_back(2'b00);
    for (int p = 0; p < bn; p++) begin
      for (int i = 0; i < BW; i++) mq.push_back(2'b01);
      for (int i = 0; i < BW; i++) mq.push_back(2'b00);
    end
    mq.push_back(2'b11);
  endtask

  always begin : compare
    logic           s_start;
    logic [3:0]     s_bn;
    logic [CW-1:0]  s_hl;
    logic [1:0]     e;
    @(posedge clk);
    s_start = start;
    s_bn    = bounce_n;
    s_hl    = hold_len;
    #1;
    if (!rst) begin
      mq.delete();
      m_busy = 1'b0;
      m_cnt  = '0;
      e_key = 1'b1; e_busy = 1'b0; e_done = 1'b0;
    end else begin
      if (mq.size() == 0 && !m_busy && s_start) build_seq(s_bn, s_hl);
      if (mq.size() > 0) begin
        e = mq.pop_front();
        e_key = e[0]; e_busy = 1'b1; e_done = e[1];
        if (e[1]) m_cnt = m_cnt + 1'b1;
      end else begin
        e_key = 1'b1; e_busy = 1'b0; e_done = 1'b0;
      end
      m_busy = e_busy;
    end
    if (chk_en) begin
      chk("cyc_key", key_out, e_key);
      chk("cyc_busy", busy, e_busy);
      chk("cyc_done", done, e_done);
      chk("cyc_press_cnt", press_cnt, m_cnt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_pulse(input logic [3:0] bn, input logic [CW-1:0] hl);
    @(negedge clk);
    bounce_n = bn; hold_len = hl; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble settings mid-sequence; they must not matter.
    bounce_n = 4'd7; hold_len = 16'd9;
  endtask

  // Called at the negedge of the first busy cycle; returns at the first idle negedge.
  task automatic capture(input bit repulse, output logic [63:0] trace,
                         output int nbusy, output int ndone, output bit tmo);
    int idx;
    trace = '0; nbusy = 0; ndone = 0; idx = 0;
    while (idx < 200) begin
      if (!busy) break;
      nbusy++;
      trace = {trace[62:0], key_out};
      if (done) ndone++;
      start = repulse && (idx == 5 || idx == 9);
      idx++;
      @(negedge clk);
    end
    start = 1'b0;
    tmo = (idx >= 200);
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : stim
    logic [63:0]    tr;
    int             nb, nd, last;
    int             bad;
    bit             tmo;
    logic [PCW-1:0] p0;

    // 1: reset with clock running
    #15 rst = 1'b0; chk_en = 1'b1;
    #1;
    chk("s1_rst_key", key_out, 1'b1);
    chk("s1_rst_busy", busy, 1'b0);
    chk("s1_rst_done", done, 1'b0);
    chk("s1_rst_cnt", press_cnt, 8'd0);
    @(negedge clk); @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("s1_idle_key", key_out, 1'b1);
    chk("s1_idle_busy", busy, 1'b0);
    chk("s1_idle_cnt", press_cnt, 8'd0);

    // 2: bounce 2, hold 5
    start_pulse(4'd2, 16'd5);
    capture(1'b0, tr, nb, nd, tmo);
    chk("s2_timeout", tmo, 1'b0);
    chk("s2_busy_cycles", nb, 22);
    chk("s2_wave", tr[31:0], 22'b0011001100000110011001);
    chk("s2_done_pulses", nd, 1);
    chk("s2_press_cnt", press_cnt, 8'd1);

    // 3: clean edges, hold 0 -> one low cycle
    start_pulse(4'd0, 16'd0);
    capture(1'b0, tr, nb, nd, tmo);
    chk("s3_timeout", tmo, 1'b0);
    chk("s3_busy_cycles", nb, 2);
    chk("s3_wave", tr[31:0], 2'b01);
    chk("s3_done_pulses", nd, 1);

    // 4: start re-pulsed during HOLD and REL_B
    p0 = press_cnt;
    start_pulse(4'd1, 16'd4);
    capture(1'b1, tr, nb, nd, tmo);
    chk("s4_timeout", tmo, 1'b0);
    chk("s4_busy_cycles", nb, 13);
    chk("s4_wave", tr[31:0], 13'b0011000011001);
    chk("s4_done_pulses", nd, 1);
    repeat (3) @(negedge clk);
    chk("s4_no_requeue", busy, 1'b0);
    chk("s4_press_delta", press_cnt, p0 + 8'd1);

    // 6: reset mid PRESS_B while key is low
    start_pulse(4'd2, 16'd5);
    chk("s6_pre_key", key_out, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("s6_async_key", key_out, 1'b1);
    chk("s6_async_busy", busy, 1'b0);
    chk("s6_async_cnt", press_cnt, 8'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    start_pulse(4'd2, 16'd5);
    capture(1'b0, tr, nb, nd, tmo);
    chk("s6_timeout", tmo, 1'b0);
    chk("s6_busy_cycles", nb, 22);
    chk("s6_wave", tr[31:0], 22'b0011001100000110011001);
    chk("s6_press_cnt", press_cnt, 8'd1);

    // 5: start held high, 256 back-to-back sequences
    pulse_reset();
    @(negedge clk);
    bounce_n = 4'd0; hold_len = 16'd1; start = 1'b1;
    nd = 0; last = 0; bad = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (nd > 1 && cyc - last != 3) bad++;
        last = cyc;
        if (nd == 255) chk("s5_cnt_255", press_cnt, 8'd255);
        if (nd == 256) begin
          chk("s5_cnt_wrap", press_cnt, 8'd0);
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    chk("s5_done_total", nd, 256);
    chk("s5_gap_errors", bad, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
